// File: rtl/exu_ctrl.sv
// exu_ctrl: issue/retire sequencer around the execute stage.
// Registers single-cycle ALU/branch results for the downstream valid/ready
// handshake, runs multi-cycle ops through the iterative MDU under a cycle
// watchdog, and raises the one-cycle front-end redirect.
module exu_ctrl #(
  parameter int XLEN        = 32,
  parameter int PC_W        = 32,
  parameter int MDU_TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [PC_W-1:0] in_pc_i,
  input  logic            in_multi_i,
  input  logic            in_redirect_i,
  input  logic [PC_W-1:0] npc_i,
  input  logic [XLEN-1:0] alu_res_i,
  output logic            mdu_start_o,
  output logic            mdu_kill_o,
  input  logic            mdu_done_i,
  input  logic [XLEN-1:0] mdu_res_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [PC_W-1:0] out_pc_o,
  output logic [XLEN-1:0] out_res_o,
  output logic            out_err_o,
  output logic            redirect_valid_o,
  output logic [PC_W-1:0] redirect_pc_o,
  input  logic            flush_i,
  output logic            busy_o
);

  localparam int CNT_W = $clog2(MDU_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MDU_TIMEOUT);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MDU   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              mdu_start_r;
  logic              out_valid_r;
  logic [PC_W-1:0]   out_pc_r;
  logic [XLEN-1:0]   out_res_r;
  logic              out_err_r;
  logic              redirect_valid_r;
  logic [PC_W-1:0]   redirect_pc_r;

  logic              ready_s;
  logic              accept_s;
  logic              done_s;
  logic              timeout_s;
  logic              kill_s;

  // Acceptance, effective MDU completion and watchdog/flush kill decode.
  always_comb begin
    ready_s   = 1'b0;
    accept_s  = 1'b0;
    done_s    = 1'b0;
    timeout_s = 1'b0;
    kill_s    = 1'b0;
    if (rst) begin
      // Everything is being discarded; no kill is issued on reset.
      ready_s = 1'b0;
      kill_s  = 1'b0;
    end else begin
      ready_s  = !flush_i && ((state_r == EMPTY) || ((state_r == FULL) && out_ready_i));
      accept_s = in_valid_i && ready_s;
      // Done is ignored in the launch cycle; the MDU has not started yet.
      done_s    = (state_r == MDU) && !mdu_start_r && mdu_done_i;
      timeout_s = (state_r == MDU) && (cnt_r == TIMEOUT_C);
      // Done beats timeout in the same cycle.
      kill_s    = (state_r == MDU) && (flush_i || (timeout_s && !done_s));
    end
  end

  // Sequencer FSM with all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= EMPTY;
      cnt_r            <= '0;
      mdu_start_r      <= 1'b0;
      out_valid_r      <= 1'b0;
      out_pc_r         <= '0;
      out_res_r        <= '0;
      out_err_r        <= 1'b0;
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= '0;
    end else begin
      mdu_start_r      <= 1'b0;
      redirect_valid_r <= 1'b0;
      if (flush_i) begin
        // Flush drops the held op, any in-flight MDU op and any redirect.
        state_r     <= EMPTY;
        out_valid_r <= 1'b0;
        cnt_r       <= '0;
      end else begin
        case (state_r)
          EMPTY, FULL: begin
            if (accept_s) begin
              out_pc_r  <= in_pc_i;
              out_err_r <= 1'b0;
              if (in_multi_i) begin
                state_r     <= MDU;
                mdu_start_r <= 1'b1;
                cnt_r       <= CNT_W'(1);
                out_valid_r <= 1'b0;
              end else begin
                state_r          <= FULL;
                out_valid_r      <= 1'b1;
                out_res_r        <= alu_res_i;
                redirect_valid_r <= in_redirect_i;
                if (in_redirect_i) begin
                  redirect_pc_r <= npc_i;
                end else begin
                  redirect_pc_r <= redirect_pc_r;
                end
              end
            end else if ((state_r == FULL) && out_ready_i) begin
              state_r     <= EMPTY;
              out_valid_r <= 1'b0;
            end else begin
              state_r <= state_r;
            end
          end
          MDU: begin
            if (done_s) begin
              state_r     <= FULL;
              out_valid_r <= 1'b1;
              out_res_r   <= mdu_res_i;
              out_err_r   <= 1'b0;
              cnt_r       <= '0;
            end else if (timeout_s) begin
              state_r     <= FULL;
              out_valid_r <= 1'b1;
              out_res_r   <= '1;
              out_err_r   <= 1'b1;
              cnt_r       <= '0;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
          default: begin
            state_r     <= EMPTY;
            out_valid_r <= 1'b0;
            cnt_r       <= '0;
          end
        endcase
      end
    end
  end

  assign in_ready_o       = ready_s;
  assign mdu_kill_o       = kill_s;
  assign mdu_start_o      = mdu_start_r;
  assign out_valid_o      = out_valid_r;
  assign out_pc_o         = out_pc_r;
  assign out_res_o        = out_res_r;
  assign out_err_o        = out_err_r;
  assign redirect_valid_o = redirect_valid_r;
  assign redirect_pc_o    = redirect_pc_r;
  assign busy_o           = (state_r != EMPTY);

endmodule

// File: tb/tb_exu_ctrl.sv
// Directed self-checking bench for exu_ctrl (MDU_TIMEOUT = 4).
module tb_exu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] in_pc_i = 32'h0;
  logic        in_multi_i = 1'b0;
  logic        in_redirect_i = 1'b0;
  logic [31:0] npc_i = 32'h0;
  logic [31:0] alu_res_i = 32'h0;
  logic        mdu_start_o;
  logic        mdu_kill_o;
  logic        mdu_done_i = 1'b0;
  logic [31:0] mdu_res_i = 32'h0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [31:0] out_pc_o;
  logic [31:0] out_res_o;
  logic        out_err_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        flush_i = 1'b0;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  exu_ctrl #(.XLEN(32), .PC_W(32), .MDU_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_pc_i(in_pc_i),
    .in_multi_i(in_multi_i), .in_redirect_i(in_redirect_i), .npc_i(npc_i),
    .alu_res_i(alu_res_i), .mdu_start_o(mdu_start_o), .mdu_kill_o(mdu_kill_o),
    .mdu_done_i(mdu_done_i), .mdu_res_i(mdu_res_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_pc_o(out_pc_o), .out_res_o(out_res_o),
    .out_err_o(out_err_o), .redirect_valid_o(redirect_valid_o),
    .redirect_pc_o(redirect_pc_o), .flush_i(flush_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid_i = 1'b1; alu_res_i = 32'h55; in_pc_i = 32'h40; in_redirect_i = 1'b1; npc_i = 32'h99;
    step(); step();
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0h exp 0", out_valid_o); end
    checks++; if (out_pc_o !== 32'h0) begin errors++; $display("FAIL rst_out_pc: got %0h exp 0", out_pc_o); end
    checks++; if (out_res_o !== 32'h0) begin errors++; $display("FAIL rst_out_res: got %0h exp 0", out_res_o); end
    checks++; if (redirect_valid_o !== 1'b0 || redirect_pc_o !== 32'h0) begin errors++; $display("FAIL rst_redirect: got %0h/%0h exp 0/0", redirect_valid_o, redirect_pc_o); end
    checks++; if ({mdu_start_o, mdu_kill_o, out_err_o, busy_o, in_ready_o} !== 5'b0) begin errors++; $display("FAIL rst_misc: got %b exp 00000", {mdu_start_o, mdu_kill_o, out_err_o, busy_o, in_ready_o}); end
    in_valid_i = 1'b0; in_redirect_i = 1'b0; rst = 1'b0;
    #1;
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %0h exp 1", in_ready_o); end
  endtask

  task automatic test_back_to_back();
    out_ready_i = 1'b1;
    in_valid_i = 1'b1; in_pc_i = 32'h8000_0000; alu_res_i = 32'd5;
    step();
    checks++; if (out_valid_o !== 1'b1 || out_res_o !== 32'd5 || out_pc_o !== 32'h8000_0000) begin errors++; $display("FAIL b2b_first: got v=%0h res=%0h pc=%0h exp 1/5/80000000", out_valid_o, out_res_o, out_pc_o); end
    in_pc_i = 32'h8000_0004; alu_res_i = 32'd7;
    #1;
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %0h exp 1", in_ready_o); end
    step();
    checks++; if (out_valid_o !== 1'b1 || out_res_o !== 32'd7 || out_pc_o !== 32'h8000_0004) begin errors++; $display("FAIL b2b_second: got v=%0h res=%0h pc=%0h exp 1/7/80000004", out_valid_o, out_res_o, out_pc_o); end
    checks++; if (out_err_o !== 1'b0 || redirect_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_err_redir: got %0h/%0h exp 0/0", out_err_o, redirect_valid_o); end
    in_valid_i = 1'b0;
    step();
    checks++; if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL b2b_drain: got v=%0h busy=%0h exp 0/0", out_valid_o, busy_o); end
  endtask

  task automatic test_jal_redirect();
    in_valid_i = 1'b1; in_redirect_i = 1'b1; in_pc_i = 32'h8000_0008; npc_i = 32'h8000_0100; alu_res_i = 32'h8000_000c;
    step();
    in_valid_i = 1'b0; in_redirect_i = 1'b0;
    checks++; if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h8000_0100) begin errors++; $display("FAIL jal_pulse: got %0h/%0h exp 1/80000100", redirect_valid_o, redirect_pc_o); end
    checks++; if (out_res_o !== 32'h8000_000c) begin errors++; $display("FAIL jal_link: got %0h exp 8000000c", out_res_o); end
    step();
    checks++; if (redirect_valid_o !== 1'b0) begin errors++; $display("FAIL jal_pulse_end: got %0h exp 0", redirect_valid_o); end
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; in_redirect_i = 1'b1; in_pc_i = 32'h8000_0010; npc_i = 32'h8000_0200;
    step();
    in_valid_i = 1'b0; in_redirect_i = 1'b0;
    checks++; if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h8000_0200) begin errors++; $display("FAIL jal_bp_pulse: got %0h/%0h exp 1/80000200", redirect_valid_o, redirect_pc_o); end
    step();
    checks++; if (redirect_valid_o !== 1'b0 || out_valid_o !== 1'b1) begin errors++; $display("FAIL jal_bp_once: got redir=%0h v=%0h exp 0/1", redirect_valid_o, out_valid_o); end
    out_ready_i = 1'b1;
    step();
  endtask

  task automatic test_mdu();
    in_valid_i = 1'b1; in_multi_i = 1'b1; in_redirect_i = 1'b1; in_pc_i = 32'h8000_0020; npc_i = 32'h8000_0300;
    step();
    in_valid_i = 1'b0; in_multi_i = 1'b0; in_redirect_i = 1'b0;
    checks++; if (mdu_start_o !== 1'b1 || busy_o !== 1'b1 || out_valid_o !== 1'b0) begin errors++; $display("FAIL mdu_start: got st=%0h busy=%0h v=%0h exp 1/1/0", mdu_start_o, busy_o, out_valid_o); end
    checks++; if (redirect_valid_o !== 1'b0 || in_ready_o !== 1'b0 || out_pc_o !== 32'h8000_0020) begin errors++; $display("FAIL mdu_side: got redir=%0h rdy=%0h pc=%0h exp 0/0/80000020", redirect_valid_o, in_ready_o, out_pc_o); end
    mdu_done_i = 1'b1; mdu_res_i = 32'hdead_beef;
    step();
    mdu_done_i = 1'b0;
    checks++; if (mdu_start_o !== 1'b0 || out_valid_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL mdu_early_done: got st=%0h v=%0h busy=%0h exp 0/0/1", mdu_start_o, out_valid_o, busy_o); end
    step();
    mdu_done_i = 1'b1; mdu_res_i = 32'h1234_5678;
    #1;
    checks++; if (mdu_kill_o !== 1'b0) begin errors++; $display("FAIL mdu_done_wins: got kill=%0h exp 0", mdu_kill_o); end
    step();
    mdu_done_i = 1'b0;
    checks++; if (out_valid_o !== 1'b1 || out_res_o !== 32'h1234_5678 || out_err_o !== 1'b0) begin errors++; $display("FAIL mdu_result: got v=%0h res=%0h err=%0h exp 1/12345678/0", out_valid_o, out_res_o, out_err_o); end
    checks++; if (out_pc_o !== 32'h8000_0020 || mdu_start_o !== 1'b0) begin errors++; $display("FAIL mdu_pc: got pc=%0h st=%0h exp 80000020/0", out_pc_o, mdu_start_o); end
    step();
  endtask

  task automatic test_mdu_timeout();
    in_valid_i = 1'b1; in_multi_i = 1'b1; in_pc_i = 32'h8000_0030;
    step();
    in_valid_i = 1'b0; in_multi_i = 1'b0;
    checks++; if (mdu_kill_o !== 1'b0) begin errors++; $display("FAIL to_kill_c1: got %0h exp 0", mdu_kill_o); end
    step(); step();
    checks++; if (mdu_kill_o !== 1'b0) begin errors++; $display("FAIL to_kill_c3: got %0h exp 0", mdu_kill_o); end
    step();
    checks++; if (mdu_kill_o !== 1'b1 || out_valid_o !== 1'b0) begin errors++; $display("FAIL to_kill_c4: got kill=%0h v=%0h exp 1/0", mdu_kill_o, out_valid_o); end
    step();
    checks++; if (out_valid_o !== 1'b1 || out_res_o !== 32'hffff_ffff || out_err_o !== 1'b1) begin errors++; $display("FAIL to_result: got v=%0h res=%0h err=%0h exp 1/ffffffff/1", out_valid_o, out_res_o, out_err_o); end
    checks++; if (mdu_kill_o !== 1'b0 || out_pc_o !== 32'h8000_0030) begin errors++; $display("FAIL to_after: got kill=%0h pc=%0h exp 0/80000030", mdu_kill_o, out_pc_o); end
    step();
  endtask

  task automatic test_backpressure_flush();
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; in_pc_i = 32'h8000_0040; alu_res_i = 32'h0000_0abc;
    step();
    in_pc_i = 32'h8000_0044; alu_res_i = 32'h0000_0111;
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %0h exp 0", i, in_ready_o); end
      step();
      checks++; if (out_valid_o !== 1'b1 || out_res_o !== 32'h0000_0abc || out_pc_o !== 32'h8000_0040) begin errors++; $display("FAIL bp_stable[%0d]: got v=%0h res=%0h pc=%0h exp 1/abc/80000040", i, out_valid_o, out_res_o, out_pc_o); end
    end
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    step();
    // Flush while a redirect pulse is already visible.
    in_valid_i = 1'b1; in_redirect_i = 1'b1; in_pc_i = 32'h8000_0050; npc_i = 32'h8000_0400;
    step();
    in_valid_i = 1'b1; in_redirect_i = 1'b1; in_pc_i = 32'h8000_0054; npc_i = 32'h8000_0500;
    flush_i = 1'b1;
    #1;
    checks++; if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h8000_0400 || in_ready_o !== 1'b0) begin errors++; $display("FAIL fl_redir_kept: got %0h/%0h rdy=%0h exp 1/80000400/0", redirect_valid_o, redirect_pc_o, in_ready_o); end
    step();
    flush_i = 1'b0; in_valid_i = 1'b0; in_redirect_i = 1'b0;
    checks++; if (out_valid_o !== 1'b0 || redirect_valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL fl_full: got v=%0h redir=%0h busy=%0h exp 0/0/0", out_valid_o, redirect_valid_o, busy_o); end
    // Flush during an MDU op.
    in_valid_i = 1'b1; in_multi_i = 1'b1; in_pc_i = 32'h8000_0060;
    step();
    in_valid_i = 1'b0; in_multi_i = 1'b0;
    step();
    flush_i = 1'b1; mdu_done_i = 1'b1; mdu_res_i = 32'h0bad_0bad;
    in_valid_i = 1'b1; in_pc_i = 32'h8000_0064; alu_res_i = 32'h0000_0077;
    #1;
    checks++; if (mdu_kill_o !== 1'b1 || in_ready_o !== 1'b0) begin errors++; $display("FAIL fl_mdu_kill: got kill=%0h rdy=%0h exp 1/0", mdu_kill_o, in_ready_o); end
    step();
    flush_i = 1'b0; in_valid_i = 1'b0;
    checks++; if (busy_o !== 1'b0 || out_valid_o !== 1'b0 || mdu_kill_o !== 1'b0) begin errors++; $display("FAIL fl_mdu_empty: got busy=%0h v=%0h kill=%0h exp 0/0/0", busy_o, out_valid_o, mdu_kill_o); end
    step();
    mdu_done_i = 1'b0;
    checks++; if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL fl_late_done: got v=%0h busy=%0h exp 0/0", out_valid_o, busy_o); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_jal_redirect();
    test_mdu();
    test_mdu_timeout();
    test_backpressure_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish exp finish before 100000");
    $fatal(1);
  end

endmodule
